// File: rtl/cam_search_ctrl.sv
// Search controller that makes a single-port RAM behave as a CAM.
// Writes go through in one cycle; a search scans addresses upward until the first match or the end of memory.
module cam_search_ctrl #(
  parameter int DATA_WIDTH = 14,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  input  logic                  srch_req,
  input  logic [DATA_WIDTH-1:0] srch_key,
  output logic                  srch_busy,
  output logic                  srch_done,
  output logic                  srch_hit,
  output logic [ADDR_WIDTH-1:0] srch_addr,
  output logic                  ram_we,
  output logic                  ram_match_en,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  typedef enum logic [1:0] {IDLE, WRITE, SCAN, DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] key;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  last_wr;
  logic                  rd_vld;
  logic                  cmp_vld;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] cmp_addr;
  logic                  key_eq;

  assign key_eq = (dout_q == key);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      key          <= '0;
      dout_q       <= '0;
      last_wr      <= 1'b0;
      rd_vld       <= 1'b0;
      cmp_vld      <= 1'b0;
      rd_addr      <= '0;
      cmp_addr     <= '0;
      wr_ack       <= 1'b0;
      srch_busy    <= 1'b0;
      srch_done    <= 1'b0;
      srch_hit     <= 1'b0;
      srch_addr    <= '0;
      ram_we       <= 1'b0;
      ram_match_en <= 1'b0;
      ram_din      <= '0;
      ram_addr     <= '0;
    end else begin
      // Read pipeline: stage 1 = RAM access, stage 2 = registered data ready to compare.
      rd_vld   <= (state == SCAN) && ram_match_en;
      rd_addr  <= ram_addr;
      dout_q   <= ram_dout;
      cmp_vld  <= (state == SCAN) && rd_vld;
      cmp_addr <= rd_addr;

      case (state)
        IDLE: begin
          if (wr_req && (!srch_req || !last_wr)) begin
            state    <= WRITE;
            last_wr  <= 1'b1;
            wr_ack   <= 1'b1;
            ram_we   <= 1'b1;
            ram_addr <= wr_addr;
            ram_din  <= wr_data;
          end else if (srch_req) begin
            state        <= SCAN;
            last_wr      <= 1'b0;
            key          <= srch_key;
            srch_busy    <= 1'b1;
            srch_hit     <= 1'b0;
            srch_addr    <= '0;
            ram_match_en <= 1'b1;
            ram_addr     <= '0;
          end
        end
        WRITE: begin
          wr_ack <= 1'b0;
          ram_we <= 1'b0;
          state  <= IDLE;
        end
        SCAN: begin
          // ram_addr doubles as the scan pointer; it parks on LAST rather than wrapping.
          if (ram_match_en) begin
            if (ram_addr == LAST) ram_match_en <= 1'b0;
            else                  ram_addr     <= ram_addr + 1'b1;
          end
          if (cmp_vld && (key_eq || cmp_addr == LAST)) begin
            state        <= DONE;
            srch_busy    <= 1'b0;
            srch_done    <= 1'b1;
            srch_hit     <= key_eq;
            srch_addr    <= key_eq ? cmp_addr : '0;
            ram_match_en <= 1'b0;
          end
        end
        DONE: begin
          srch_done <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
